wasm_fetch_decode: RTL and testbench

- Parametrised front end for the Wasm stack CPU: fetches the opcode byte, decodes any LEB128 immediate (unsigned and signed, 32/64-bit), and issues {opcode, immediate, pc} to the execute stage over a valid/ready handshake.
- Adds what the single-process core lacks: signed decode with sign extension, per-opcode length limits and an error state, execute backpressure, and a pc redirect for call/branch.

---
 rtl/wasm_fetch_decode_pkg.sv | 62 ++++++
 rtl/wasm_fetch_decode_if.sv | 40 ++++
 rtl/wasm_fetch_decode_leb128_accum.sv | 80 ++++++++
 rtl/wasm_fetch_decode.sv | 151 +++++++++++++++
 tb/tb_wasm_fetch_decode.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/wasm_fetch_decode_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wasm_pkg
// Purpose  : Shared definitions for the Wasm fetch/decode front end. Holds the
//            opcode constants, the immediate-kind and FSM state enums, and
//            helpers that map an opcode to its immediate encoding and that
//            encoding to its maximum LEB128 length.
// Revision : 1.0 - initial release
// ============================================================================
package wasm_pkg;

    localparam logic [7:0] I32_CONST   = 8'h41;
    localparam logic [7:0] I64_CONST   = 8'h42;
    localparam logic [7:0] CALL        = 8'h10;
    localparam logic [7:0] BR          = 8'h0C;
    localparam logic [7:0] BR_IF       = 8'h0D;
    localparam logic [7:0] LOCAL_GET   = 8'h20;
    localparam logic [7:0] LOCAL_SET   = 8'h21;
    localparam logic [7:0] LOCAL_TEE   = 8'h22;
    localparam logic [7:0] I32_ADD     = 8'h6A;
    localparam logic [7:0] I32_MUL     = 8'h6C;
    localparam logic [7:0] DROP        = 8'h1A;
    localparam logic [7:0] END_OF_FUNC = 8'h0B;

    typedef enum logic [1:0] {
        IMM_NONE = 2'd0,
        IMM_U32  = 2'd1,
        IMM_S32  = 2'd2,
        IMM_S64  = 2'd3
    } imm_kind_t;

    typedef enum logic [1:0] {
        ST_FETCH_OP  = 2'd0,
        ST_FETCH_IMM = 2'd1,
        ST_ISSUE     = 2'd2,
        ST_ERROR     = 2'd3
    } fd_state_t;

    function automatic imm_kind_t imm_kind(input logic [7:0] opcode);
        imm_kind_t k;
        case (opcode)
            I32_CONST:                         k = IMM_S32;
            I64_CONST:                         k = IMM_S64;
            CALL, BR, BR_IF,
            LOCAL_GET, LOCAL_SET, LOCAL_TEE:   k = IMM_U32;
            default:                           k = IMM_NONE;
        endcase
        return k;
    endfunction

    function automatic logic [3:0] imm_max_bytes(input imm_kind_t kind);
        logic [3:0] n;
        case (kind)
            IMM_S64:  n = 4'd10;
            IMM_NONE: n = 4'd0;
            default:  n = 4'd5;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wasm_fetch_decode_if.sv
`default_nettype none
// ============================================================================
// Module   : wasm_fetch_decode_if
// Purpose  : Bundles the byte-memory read port, the decoded-instruction issue
//            handshake, the pc redirect and the error flag.
//            master : the fetch/decode block
//            slave  : memory + execute stage
// Revision : 1.0 - initial release
// ============================================================================
interface wasm_fetch_decode_if #(
    parameter int ADDR_W = 32,
    parameter int IMM_W  = 64
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read_en;
    logic [7:0]        mem_rdata;
    logic              mem_ready;
    logic              instr_valid;
    logic              instr_ready;
    logic [7:0]        instr_opcode;
    logic [IMM_W-1:0]  instr_imm;
    logic [ADDR_W-1:0] instr_pc;
    logic [ADDR_W-1:0] next_pc;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              err;

    modport master (
        output mem_addr, mem_read_en, instr_valid, instr_opcode, instr_imm,
               instr_pc, next_pc, err,
        input  mem_rdata, mem_ready, instr_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  mem_addr, mem_read_en, instr_valid, instr_opcode, instr_imm,
               instr_pc, next_pc, err,
        output mem_rdata, mem_ready, instr_ready, redirect_valid, redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/wasm_fetch_decode_leb128_accum.sv
`default_nettype none
// ============================================================================
// Module   : leb128_accum
// Purpose  : Byte-serial LEB128 accumulator.
//            clear     : zero the value and byte count
//            shift_in  : fold data_byte into the value this cycle
//            is_signed : sign-extend on the terminating byte
//            kind      : immediate kind (sets width and length limit)
//            value     : accumulated immediate, already width-adjusted
//            done      : the byte being shifted in terminates the encoding
//            overflow  : the byte being shifted in asks for one byte too many
// Revision : 1.0 - initial release
// ============================================================================
module leb128_accum
    import wasm_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        clear,
    input  wire logic        shift_in,
    input  wire logic [7:0]  data_byte,
    input  wire logic        is_signed,
    input  wire imm_kind_t   kind,
    output logic [63:0]      value,
    output logic             done,
    output logic             overflow
);

    logic [63:0] r_acc;
    logic [3:0]  r_count;

    logic [6:0]  w_shamt;
    logic [63:0] w_payload;
    logic [63:0] w_sign_fill;
    logic [63:0] w_merged;
    logic [63:0] w_next;
    logic        w_last;

    assign w_last    = ~data_byte[7];
    assign w_shamt   = 7'(r_count) * 7'd7;
    assign w_payload = 64'(data_byte[6:0]) << w_shamt;

    // Ones from just above this byte's payload to the top; shifts of 64 or
    // more naturally yield zero, so the 10th S64 byte adds no fill.
    assign w_sign_fill = (is_signed && w_last && data_byte[6])
                       ? (~64'd0 << (w_shamt + 7'd7)) : 64'd0;

    assign w_merged = r_acc | w_payload | w_sign_fill;

    // Bits beyond the kind's width are dropped; S32 is then extended from
    // bit 31 so a 5th byte can legitimately set the sign.
    always_comb begin
        w_next = w_merged;
        case (kind)
            IMM_S64: w_next = w_merged;
            IMM_S32: w_next = {{32{w_merged[31]}}, w_merged[31:0]};
            default: w_next = {32'd0, w_merged[31:0]};
        endcase
    end

    assign done     = shift_in & w_last;
    assign overflow = shift_in & data_byte[7]
                    & (({1'b0, r_count} + 5'd1) >= {1'b0, imm_max_bytes(kind)});
    assign value    = r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= 64'd0;
            r_count <= 4'd0;
        end else if (clear) begin
            r_acc   <= 64'd0;
            r_count <= 4'd0;
        end else if (shift_in) begin
            r_acc   <= w_next;
            r_count <= r_count + 4'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wasm_fetch_decode.sv
`default_nettype none
// ============================================================================
// Module   : wasm_fetch_decode
// Purpose  : Wasm front end. Fetches an opcode byte, decodes its LEB128
//            immediate (U32/S32/S64), and issues {opcode, imm, pc, next_pc}
//            over a valid/ready handshake. A redirect from execute overrides
//            everything; malformed immediates park the block in ERROR.
// Ports    : clk, rst_n (async, active-low)
//            bus : wasm_fetch_decode_if.master (memory read port, issue
//                  handshake, redirect, err)
// Revision : 1.0 - initial release
// ============================================================================
module wasm_fetch_decode
    import wasm_pkg::*;
#(
    parameter int          ADDR_W   = 32,
    parameter int          IMM_W    = 64,
    parameter int unsigned RESET_PC = 32'h1A
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    wasm_fetch_decode_if.master  bus
);

    fd_state_t         r_state;
    fd_state_t         w_state_nxt;
    logic              r_run;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [7:0]        r_opcode;
    logic [ADDR_W-1:0] r_instr_pc;
    logic [ADDR_W-1:0] r_next_pc;
    imm_kind_t         r_kind;

    logic              w_read_en;
    logic              w_beat;
    logic              w_acc_clear;
    logic              w_acc_shift;
    logic [63:0]       w_acc_value;
    logic              w_acc_done;
    logic              w_acc_ovf;
    logic              w_kind_signed;

    // r_run holds the read request low for the first cycle out of reset.
    assign w_read_en = r_run && (r_state == ST_FETCH_OP || r_state == ST_FETCH_IMM);
    assign w_beat    = w_read_en && bus.mem_ready;
    assign w_pc_inc  = r_pc + ADDR_W'(1);
    assign w_kind_signed = (r_kind == IMM_S32) || (r_kind == IMM_S64);

    leb128_accum u_accum (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (w_acc_clear),
        .shift_in  (w_acc_shift),
        .data_byte (bus.mem_rdata),
        .is_signed (w_kind_signed),
        .kind      (r_kind),
        .value     (w_acc_value),
        .done      (w_acc_done),
        .overflow  (w_acc_ovf)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_acc_clear = 1'b0;
        w_acc_shift = 1'b0;
        case (r_state)
            ST_FETCH_OP: begin
                if (w_beat) begin
                    w_acc_clear = 1'b1;
                    if (IMM_W == 32 && bus.mem_rdata == I64_CONST)
                        w_state_nxt = ST_ERROR;
                    else if (imm_kind(bus.mem_rdata) != IMM_NONE)
                        w_state_nxt = ST_FETCH_IMM;
                    else
                        w_state_nxt = ST_ISSUE;
                end
            end
            ST_FETCH_IMM: begin
                if (w_beat) begin
                    w_acc_shift = 1'b1;
                    if (w_acc_ovf)
                        w_state_nxt = ST_ERROR;
                    else if (w_acc_done)
                        w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.instr_ready)
                    w_state_nxt = ST_FETCH_OP;
            end
            ST_ERROR: begin
                w_state_nxt = ST_ERROR;
            end
            default: begin
                w_state_nxt = ST_FETCH_OP;
            end
        endcase

        // Redirect wins over any beat or handshake in the same cycle.
        if (bus.redirect_valid) begin
            w_state_nxt = ST_FETCH_OP;
            w_acc_clear = 1'b1;
            w_acc_shift = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH_OP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run      <= 1'b0;
            r_pc       <= ADDR_W'(RESET_PC);
            r_opcode   <= 8'd0;
            r_instr_pc <= '0;
            r_next_pc  <= '0;
            r_kind     <= IMM_NONE;
        end else begin
            r_run <= 1'b1;
            if (bus.redirect_valid) begin
                r_pc <= bus.redirect_pc;
            end else if (w_beat) begin
                r_pc <= w_pc_inc;
                if (r_state == ST_FETCH_OP) begin
                    r_opcode   <= bus.mem_rdata;
                    r_instr_pc <= r_pc;
                    r_kind     <= imm_kind(bus.mem_rdata);
                end
                if (w_state_nxt == ST_ISSUE)
                    r_next_pc <= w_pc_inc;
            end
        end
    end

    assign bus.mem_addr     = r_pc;
    assign bus.mem_read_en  = w_read_en;
    assign bus.instr_valid  = (r_state == ST_ISSUE);
    assign bus.instr_opcode = r_opcode;
    assign bus.instr_imm    = w_acc_value[IMM_W-1:0];
    assign bus.instr_pc     = r_instr_pc;
    assign bus.next_pc      = r_next_pc;
    assign bus.err          = (r_state == ST_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_wasm_fetch_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_wasm_fetch_decode
// Purpose  : Directed self-checking bench for wasm_fetch_decode. A byte
//            memory model answers reads (zero-wait or random wait states);
//            expected decode results are hand-computed constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wasm_fetch_decode;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int ready_mode  = 0;   // 0: zero-wait memory, 1: random wait states
    int call_issued = 0;

    logic [7:0] mem [0:1023];

    wasm_fetch_decode_if #(.ADDR_W(32), .IMM_W(64)) bus ();

    wasm_fetch_decode #(
        .ADDR_W   (32),
        .IMM_W    (64),
        .RESET_PC (32'h1A)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.mem_rdata = mem[bus.mem_addr[9:0]];

    always @(negedge clk)
        bus.mem_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);

    always @(posedge clk)
        if (bus.instr_valid && bus.instr_ready && bus.instr_opcode == 8'h10)
            call_issued++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus.instr_valid) break;
        end
        chk({tag, "_valid"}, 64'(bus.instr_valid), 64'd1);
    endtask

    task automatic check_instr(input string tag, input logic [7:0] opc,
                               input logic [63:0] imm, input logic [31:0] ipc,
                               input logic [31:0] npc);
        wait_valid(tag);
        chk({tag, "_opcode"}, 64'(bus.instr_opcode), 64'(opc));
        chk({tag, "_imm"},    bus.instr_imm,         imm);
        chk({tag, "_pc"},     64'(bus.instr_pc),     64'(ipc));
        chk({tag, "_nextpc"}, 64'(bus.next_pc),      64'(npc));
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h01;
        // 0x1A: i32.const 624485
        mem[32'h1A] = 8'h41; mem[32'h1B] = 8'hE5; mem[32'h1C] = 8'h8E; mem[32'h1D] = 8'h26;
        // 0x1E: i32.const -1
        mem[32'h1E] = 8'h41; mem[32'h1F] = 8'h7F;
        // 0x20: i64.const -128
        mem[32'h20] = 8'h42; mem[32'h21] = 8'h80; mem[32'h22] = 8'h7F;
        // 0x23: i32.add
        mem[32'h23] = 8'h6A;
        // 0x24: local.set 0x3FFF (unsigned, no extension)
        mem[32'h24] = 8'h21; mem[32'h25] = 8'hFF; mem[32'h26] = 8'h7F;
        // 0x27: local.get with a 6-byte immediate -> error
        mem[32'h27] = 8'h20;
        for (int i = 32'h28; i <= 32'h2C; i++) mem[i] = 8'h80;
        // 0x40: call, redirected away mid-immediate
        mem[32'h40] = 8'h10; mem[32'h41] = 8'h81; mem[32'h42] = 8'h82; mem[32'h43] = 8'h03;
        // 0x100: i32.mul, 0x101: long i64.const interrupted by reset
        mem[32'h100] = 8'h6C;
        mem[32'h101] = 8'h42;
        for (int i = 32'h102; i <= 32'h10A; i++) mem[i] = 8'hFF;
        mem[32'h10B] = 8'h00;

        rst_n              = 1'b0;
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        repeat (2) @(negedge clk);

        chk("rst_read_en", 64'(bus.mem_read_en), 64'd0);
        chk("rst_valid",   64'(bus.instr_valid), 64'd0);
        chk("rst_err",     64'(bus.err),         64'd0);
        chk("rst_addr",    64'(bus.mem_addr),    64'h1A);
        chk("rst_imm",     bus.instr_imm,        64'd0);

        rst_n = 1'b1;
        @(negedge clk);
        chk("first_req_en",   64'(bus.mem_read_en), 64'd1);
        chk("first_req_addr", 64'(bus.mem_addr),    64'h1A);

        check_instr("i32_pos", 8'h41, 64'd624485,                32'h1A, 32'h1E);
        check_instr("i32_neg", 8'h41, 64'hFFFF_FFFF_FFFF_FFFF,   32'h1E, 32'h20);
        check_instr("i64_neg", 8'h42, 64'hFFFF_FFFF_FFFF_FF80,   32'h20, 32'h23);

        @(posedge clk);
        #1 bus.instr_ready = 1'b0;
        wait_valid("stall");
        chk("stall_opcode", 64'(bus.instr_opcode), 64'h6A);
        chk("stall_nextpc", 64'(bus.next_pc),      64'h24);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_hold_valid",  64'(bus.instr_valid),  64'd1);
            chk("stall_hold_rd",     64'(bus.mem_read_en),  64'd0);
            chk("stall_hold_opcode", 64'(bus.instr_opcode), 64'h6A);
            chk("stall_hold_pc",     64'(bus.instr_pc),     64'h23);
        end
        bus.instr_ready = 1'b1;
        @(negedge clk);
        chk("post_hs_valid", 64'(bus.instr_valid), 64'd0);
        chk("post_hs_rd",    64'(bus.mem_read_en), 64'd1);
        chk("post_hs_addr",  64'(bus.mem_addr),    64'h24);

        check_instr("u32", 8'h21, 64'h3FFF, 32'h24, 32'h27);

        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.err) break;
        end
        chk("ovf_err",   64'(bus.err),         64'd1);
        chk("ovf_rd",    64'(bus.mem_read_en), 64'd0);
        chk("ovf_valid", 64'(bus.instr_valid), 64'd0);
        chk("ovf_addr",  64'(bus.mem_addr),    64'h2D);

        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        chk("redir_err_clr", 64'(bus.err),         64'd0);
        chk("redir_rd",      64'(bus.mem_read_en), 64'd1);
        chk("redir_addr",    64'(bus.mem_addr),    64'h40);

        for (int i = 0; i < 20; i++) begin
            if (bus.mem_read_en && bus.mem_addr == 32'h42) break;
            @(negedge clk);
        end
        chk("imm2_reached", 64'(bus.mem_addr), 64'h42);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        chk("redir2_addr",  64'(bus.mem_addr),    64'h100);
        chk("redir2_rd",    64'(bus.mem_read_en), 64'd1);
        chk("redir2_valid", 64'(bus.instr_valid), 64'd0);

        check_instr("after_redir", 8'h6C, 64'd0, 32'h100, 32'h101);
        chk("call_dropped", 64'(call_issued), 64'd0);

        ready_mode = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.mem_read_en && bus.mem_addr >= 32'h104) break;
        end
        chk("mid_imm_reached", 64'(bus.mem_addr >= 32'h104), 64'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_rd",     64'(bus.mem_read_en),  64'd0);
        chk("arst_addr",   64'(bus.mem_addr),     64'h1A);
        chk("arst_valid",  64'(bus.instr_valid),  64'd0);
        chk("arst_opcode", 64'(bus.instr_opcode), 64'd0);
        chk("arst_imm",    bus.instr_imm,         64'd0);
        chk("arst_pc",     64'(bus.instr_pc),     64'd0);
        chk("arst_nextpc", 64'(bus.next_pc),      64'd0);
        chk("arst_err",    64'(bus.err),          64'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        ready_mode = 0;
        @(negedge clk);
        chk("rerst_rd",   64'(bus.mem_read_en), 64'd1);
        chk("rerst_addr", 64'(bus.mem_addr),    64'h1A);
        check_instr("rerst_i32", 8'h41, 64'd624485, 32'h1A, 32'h1E);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
